// File: rtl/testdrive_apb_regfile_slave_if.sv
// APB4 completer-side bus bundle for the TestDrive register bank.
// The master modport is used by the BFM or testbench.
// The slave modport is used by the register bank itself.
interface testdrive_apb_regfile_slave_if #(
    parameter int unsigned C_ADDR_BITS = 10
);
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [C_ADDR_BITS-1:0] PADDR;
    logic [31:0]            PWDATA;
    logic [3:0]             PSTRB;
    logic [31:0]            PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/testdrive_apb_regfile_slave.sv
// APB4 completer register bank.
// It provides C_REG_COUNT 32-bit registers with byte-strobe writes and
// read-only status slots.
// Each transfer has C_WAIT_CYCLES wait states with PREADY low.
// PSLVERR flags accesses beyond the bank and writes to read-only slots.
// Committed writes appear on REG_OUT and give a one-cycle WR_PULSE.
module testdrive_apb_regfile_slave #(
    parameter int unsigned            C_ADDR_BITS   = 10,
    parameter int unsigned            C_REG_COUNT   = 16,
    parameter int unsigned            C_WAIT_CYCLES = 0,
    parameter logic [C_REG_COUNT-1:0] C_RO_MASK     = '0,
    parameter logic [31:0]            C_RESET_VALUE = 32'h0
) (
    input  logic                        CLK,
    input  logic                        nRST,
    testdrive_apb_regfile_slave_if.slave apb,
    output logic [C_REG_COUNT*32-1:0]   REG_OUT,
    input  logic [C_REG_COUNT*32-1:0]   RO_IN,
    output logic [C_REG_COUNT-1:0]      WR_PULSE
);
    localparam int unsigned IDX_W     = C_ADDR_BITS - 2;
    localparam logic [7:0]  WAIT_LOAD = 8'((C_WAIT_CYCLES == 0) ? 0 : C_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Transfer attributes captured in the setup phase.
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       strb_q;
    logic             err_q;

    // Read view of every slot: register contents or the RO_IN status slice.
    logic [31:0] rd_vals [C_REG_COUNT];

    logic             setup;
    logic             commit;
    logic             cur_wr;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_in_range;
    logic             cur_ro;
    logic [31:0]      cur_rdata;
    logic             err_now;
    logic             resp_next;
    logic [1:0]       paddr_unused;

    // PADDR[1:0] has no meaning here; accesses are always whole words.
    assign paddr_unused = apb.PADDR[1:0];

    assign setup = (state_q == ST_IDLE) && apb.PSEL && !apb.PENABLE;

    // A write commits only when RESP closes normally.
    // A master abort (PSEL low) or an error response leaves the bank untouched.
    assign commit = (state_q == ST_RESP) && apb.PSEL && wr_q && !err_q;

    // A zero-wait transfer enters RESP at the setup edge itself.
    // So the live bus values are used there, and the captured copies afterwards.
    assign cur_wr  = setup ? apb.PWRITE : wr_q;
    assign cur_idx = setup ? apb.PADDR[C_ADDR_BITS-1:2] : idx_q;

    // Decode the addressed slot: range check, read-only flag and read data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // otherwise paths that skip an assignment infer latches.
        cur_in_range = 1'b0;
        cur_ro       = 1'b0;
        cur_rdata    = '0;
        for (int i = 0; i < int'(C_REG_COUNT); i++) begin
            if (cur_idx == IDX_W'(i)) begin
                cur_in_range = 1'b1;
                cur_ro       = C_RO_MASK[i];
                cur_rdata    = rd_vals[i];
            end
        end
    end

    assign err_now   = !cur_in_range || (cur_wr && cur_ro);
    assign resp_next = (state_d == ST_RESP);

    // FSM state register and wait-state counter.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments.
        // All flops then update together from pre-edge values.
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: setup acceptance, wait countdown, abort and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    if (C_WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the transfer attributes during the setup phase.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (setup) begin
            wr_q    <= apb.PWRITE;
            idx_q   <= apb.PADDR[C_ADDR_BITS-1:2];
            wdata_q <= apb.PWDATA;
            strb_q  <= apb.PSTRB;
            err_q   <= err_now;
        end
    end

    // Response outputs are registered on entry to RESP and zero elsewhere.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            apb.PRDATA  <= '0;
        end else begin
            apb.PREADY  <= resp_next;
            apb.PSLVERR <= resp_next && err_now;
            apb.PRDATA  <= (resp_next && !cur_wr && !err_now) ? cur_rdata : '0;
        end
    end

    // One-cycle strobe on the register written by the committing transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            WR_PULSE <= '0;
        end else begin
            for (int i = 0; i < int'(C_REG_COUNT); i++) begin
                WR_PULSE[i] <= commit && (idx_q == IDX_W'(i));
            end
        end
    end

    // Per-slot storage: writable registers or read-only status passthrough.
    for (genvar gi = 0; gi < int'(C_REG_COUNT); gi++) begin : g_reg
        if (C_RO_MASK[gi]) begin : g_ro
            assign rd_vals[gi]             = RO_IN[32*gi +: 32];
            assign REG_OUT[32*gi +: 32]    = '0;
        end else begin : g_rw
            logic [31:0] q;
            logic [31:0] ro_in_unused;

            assign ro_in_unused = RO_IN[32*gi +: 32];

            // Commit the strobed byte lanes at the edge closing RESP.
            always_ff @(posedge CLK or negedge nRST) begin
                // NOTE: this bank is a set of flops with a defined reset value.
                // It is not a RAM, so it sits on the async reset like any
                // other architecturally visible state.
                if (!nRST) begin
                    q <= C_RESET_VALUE;
                end else if (commit && (idx_q == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb_q[b]) q[8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end

            assign rd_vals[gi]          = q;
            assign REG_OUT[32*gi +: 32] = q;
        end
    end
endmodule

// File: tb/tb_testdrive_apb_regfile_slave.sv
// Self-checking bench for testdrive_apb_regfile_slave.
// Four instances cover the configurations under test:
//   u_a: no wait states
//   u_b: 3 wait states
//   u_c: 4 wait states, non-zero reset value
//   u_d: no wait states, register 0 read-only
// A shared master drives the bus and tgt routes PSEL to one instance.
module tb_testdrive_apb_regfile_slave;
    localparam int AW = 10;
    localparam int NR = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m_psel    = 1'b0;
    logic          m_penable = 1'b0;
    logic          m_pwrite  = 1'b0;
    logic [AW-1:0] m_paddr   = '0;
    logic [31:0]   m_pwdata  = '0;
    logic [3:0]    m_pstrb   = '0;
    int            tgt       = 0;
    logic [NR*32-1:0] ro_in  = '0;

    logic             s_ready  [4];
    logic             s_err    [4];
    logic [31:0]      s_rdata  [4];
    logic [NR-1:0]    s_pulse  [4];
    logic [NR*32-1:0] s_regout [4];

    testdrive_apb_regfile_slave_if #(.C_ADDR_BITS(AW)) bus0 ();
    testdrive_apb_regfile_slave_if #(.C_ADDR_BITS(AW)) bus1 ();
    testdrive_apb_regfile_slave_if #(.C_ADDR_BITS(AW)) bus2 ();
    testdrive_apb_regfile_slave_if #(.C_ADDR_BITS(AW)) bus3 ();

    assign bus0.PSEL = m_psel && (tgt == 0);
    assign bus1.PSEL = m_psel && (tgt == 1);
    assign bus2.PSEL = m_psel && (tgt == 2);
    assign bus3.PSEL = m_psel && (tgt == 3);
    assign {bus0.PENABLE, bus0.PWRITE, bus0.PADDR, bus0.PWDATA, bus0.PSTRB} = {m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb};
    assign {bus1.PENABLE, bus1.PWRITE, bus1.PADDR, bus1.PWDATA, bus1.PSTRB} = {m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb};
    assign {bus2.PENABLE, bus2.PWRITE, bus2.PADDR, bus2.PWDATA, bus2.PSTRB} = {m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb};
    assign {bus3.PENABLE, bus3.PWRITE, bus3.PADDR, bus3.PWDATA, bus3.PSTRB} = {m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb};

    assign s_ready[0] = bus0.PREADY;  assign s_err[0] = bus0.PSLVERR;  assign s_rdata[0] = bus0.PRDATA;
    assign s_ready[1] = bus1.PREADY;  assign s_err[1] = bus1.PSLVERR;  assign s_rdata[1] = bus1.PRDATA;
    assign s_ready[2] = bus2.PREADY;  assign s_err[2] = bus2.PSLVERR;  assign s_rdata[2] = bus2.PRDATA;
    assign s_ready[3] = bus3.PREADY;  assign s_err[3] = bus3.PSLVERR;  assign s_rdata[3] = bus3.PRDATA;

    testdrive_apb_regfile_slave #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NR), .C_WAIT_CYCLES(0),
        .C_RO_MASK(16'h0000), .C_RESET_VALUE(32'h0)
    ) u_a (
        .CLK(clk), .nRST(rst_n), .apb(bus0),
        .REG_OUT(s_regout[0]), .RO_IN(ro_in), .WR_PULSE(s_pulse[0])
    );

    testdrive_apb_regfile_slave #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NR), .C_WAIT_CYCLES(3),
        .C_RO_MASK(16'h0000), .C_RESET_VALUE(32'h0)
    ) u_b (
        .CLK(clk), .nRST(rst_n), .apb(bus1),
        .REG_OUT(s_regout[1]), .RO_IN(ro_in), .WR_PULSE(s_pulse[1])
    );

    testdrive_apb_regfile_slave #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NR), .C_WAIT_CYCLES(4),
        .C_RO_MASK(16'h0000), .C_RESET_VALUE(32'hA5A5_5A5A)
    ) u_c (
        .CLK(clk), .nRST(rst_n), .apb(bus2),
        .REG_OUT(s_regout[2]), .RO_IN(ro_in), .WR_PULSE(s_pulse[2])
    );

    testdrive_apb_regfile_slave #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NR), .C_WAIT_CYCLES(0),
        .C_RO_MASK(16'h0001), .C_RESET_VALUE(32'h0)
    ) u_d (
        .CLK(clk), .nRST(rst_n), .apb(bus3),
        .REG_OUT(s_regout[3]), .RO_IN(ro_in), .WR_PULSE(s_pulse[3])
    );

    typedef struct {
        int            t;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_lat;
        logic [NR-1:0] exp_pulse;
    } vec_t;

    vec_t vecs [$];
    vec_t sb   [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int t, input logic wr, input logic [AW-1:0] addr,
                                input logic [31:0] wd, input logic [3:0] st,
                                input logic [31:0] rd, input logic er, input int lat,
                                input logic [NR-1:0] pl);
        vec_t v;
        v.t = t; v.wr = wr; v.addr = addr; v.wdata = wd; v.strb = st;
        v.exp_rdata = rd; v.exp_err = er; v.exp_lat = lat; v.exp_pulse = pl;
        return v;
    endfunction

    // The task is called at a negedge, which is where the setup phase starts.
    // It returns one negedge after completion with the bus idle, so the
    // caller may start the next setup at once (back-to-back).
    task automatic xfer(input int t, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [NR-1:0] pulse, output logic ready_after);
        tgt = t; m_psel = 1'b1; m_penable = 1'b0;
        m_pwrite = wr; m_paddr = addr; m_pwdata = wd; m_pstrb = st;
        lat = 1;
        @(negedge clk);
        m_penable = 1'b1;
        lat = 2;
        while (!s_ready[t] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = s_rdata[t];
        er = s_err[t];
        @(negedge clk);
        pulse       = s_pulse[t];
        ready_after = s_ready[t];
        m_psel = 1'b0; m_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]      rd;
        logic             er;
        int               lat;
        logic [NR-1:0]    pulse;
        logic             rdy_after;
        logic [NR*32-1:0] exp_reg;
        logic             seen_rdy;
        logic [NR-1:0]    seen_pulse;
        vec_t             e;

        ro_in[31:0]  = 32'hCAFE_0001;
        ro_in[63:32] = 32'hBAD0_BAD0;

        // Fill the vector table.
        // Fields: target, wr, addr, wdata, strb | rdata, err, latency, pulse.
        vecs.push_back(mk(0, 0, 10'h000, 32'h0,         4'hF, 32'h0,         0, 2, 16'h0000));
        vecs.push_back(mk(0, 1, 10'h008, 32'hDEADBEEF, 4'hF, 32'h0,         0, 2, 16'h0004));
        vecs.push_back(mk(0, 1, 10'h008, 32'h11223344, 4'h5, 32'h0,         0, 2, 16'h0004));
        vecs.push_back(mk(0, 0, 10'h008, 32'h0,         4'h0, 32'hDE22BE44, 0, 2, 16'h0000));
        vecs.push_back(mk(0, 1, 10'h040, 32'h12345678, 4'hF, 32'h0,         1, 2, 16'h0000));
        vecs.push_back(mk(0, 0, 10'h040, 32'h0,         4'h0, 32'h0,         1, 2, 16'h0000));
        vecs.push_back(mk(0, 1, 10'h03C, 32'hAABBCCDD, 4'h8, 32'h0,         0, 2, 16'h8000));
        vecs.push_back(mk(0, 0, 10'h03F, 32'h0,         4'h0, 32'hAA000000, 0, 2, 16'h0000));
        vecs.push_back(mk(0, 1, 10'h010, 32'hFFFFFFFF, 4'h0, 32'h0,         0, 2, 16'h0010));
        vecs.push_back(mk(0, 0, 10'h012, 32'h0,         4'h0, 32'h0,         0, 2, 16'h0000));
        vecs.push_back(mk(0, 1, 10'h3FC, 32'h55555555, 4'hF, 32'h0,         1, 2, 16'h0000));
        vecs.push_back(mk(3, 0, 10'h000, 32'h0,         4'h0, 32'hCAFE0001, 0, 2, 16'h0000));
        vecs.push_back(mk(3, 1, 10'h000, 32'h99999999, 4'hF, 32'h0,         1, 2, 16'h0000));
        vecs.push_back(mk(3, 0, 10'h000, 32'h0,         4'h0, 32'hCAFE0001, 0, 2, 16'h0000));
        vecs.push_back(mk(3, 1, 10'h004, 32'h00001234, 4'hF, 32'h0,         0, 2, 16'h0002));
        vecs.push_back(mk(3, 0, 10'h004, 32'h0,         4'h0, 32'h00001234, 0, 2, 16'h0000));
        vecs.push_back(mk(1, 0, 10'h004, 32'h0,         4'h0, 32'h0,         0, 5, 16'h0000));
        vecs.push_back(mk(1, 1, 10'h004, 32'hCAFEBABE, 4'hF, 32'h0,         0, 5, 16'h0002));
        vecs.push_back(mk(1, 0, 10'h004, 32'h0,         4'h0, 32'hCAFEBABE, 0, 5, 16'h0000));
        vecs.push_back(mk(1, 0, 10'h080, 32'h0,         4'h0, 32'h0,         1, 5, 16'h0000));
        vecs.push_back(mk(2, 0, 10'h000, 32'h0,         4'h0, 32'hA5A55A5A, 0, 6, 16'h0000));
        vecs.push_back(mk(2, 1, 10'h00C, 32'h00000000, 4'h3, 32'h0,         0, 6, 16'h0008));
        vecs.push_back(mk(2, 0, 10'h00C, 32'h0,         4'h0, 32'hA5A50000, 0, 6, 16'h0000));

        // Reset state of all instances.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst%0d pready", k),  s_ready[k], 0);
            check($sformatf("rst%0d pslverr", k), s_err[k],   0);
            check($sformatf("rst%0d prdata", k),  s_rdata[k], 0);
            check($sformatf("rst%0d wr_pulse", k), s_pulse[k], 0);
        end
        for (int r = 0; r < NR; r++) exp_reg[32*r +: 32] = 32'hA5A5_5A5A;
        check("rst u_c reg_out", s_regout[2], exp_reg);
        check("rst u_a reg_out", s_regout[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transfers, all issued back-to-back.
        foreach (vecs[i]) begin
            sb.push_back(vecs[i]);
            xfer(vecs[i].t, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 rd, er, lat, pulse, rdy_after);
            e = sb.pop_front();
            check($sformatf("v%0d prdata", i),   rd,        e.exp_rdata);
            check($sformatf("v%0d pslverr", i),  er,        e.exp_err);
            check($sformatf("v%0d latency", i),  lat,       e.exp_lat);
            check($sformatf("v%0d wr_pulse", i), pulse,     e.exp_pulse);
            check($sformatf("v%0d pready_drop", i), rdy_after, 0);
        end
        check("scoreboard drained", sb.size(), 0);

        // Register contents seen on REG_OUT after the table.
        exp_reg = '0;
        exp_reg[95:64]   = 32'hDE22BE44;
        exp_reg[511:480] = 32'hAA000000;
        check("u_a reg_out", s_regout[0], exp_reg);
        exp_reg = '0;
        exp_reg[63:32] = 32'hCAFEBABE;
        check("u_b reg_out", s_regout[1], exp_reg);
        for (int r = 0; r < NR; r++) exp_reg[32*r +: 32] = 32'hA5A5_5A5A;
        exp_reg[127:96] = 32'hA5A50000;
        check("u_c reg_out", s_regout[2], exp_reg);
        exp_reg = '0;
        exp_reg[63:32] = 32'h00001234;
        check("u_d reg_out", s_regout[3], exp_reg);

        // WR_PULSE lasts exactly one cycle.
        xfer(0, 1, 10'h000, 32'h000000FF, 4'h1, rd, er, lat, pulse, rdy_after);
        check("pulse1 high", pulse, 16'h0001);
        @(negedge clk);
        check("pulse1 low", s_pulse[0], 0);
        check("pulse1 reg0", s_regout[0][31:0], 32'h000000FF);

        // PENABLE without a setup phase, and PENABLE without PSEL, are ignored.
        tgt = 0; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1;
        m_paddr = 10'h000; m_pwdata = 32'hFFFFFFFF; m_pstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("spurious en%0d pready", c), s_ready[0], 0);
        end
        m_psel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("spurious pulse", s_pulse[0], 0);
        m_penable = 1'b0;
        @(negedge clk);
        check("spurious reg0", s_regout[0][31:0], 32'h000000FF);

        // Master abort: PSEL drops in the 2nd WAIT cycle of u_b.
        tgt = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 10'h008; m_pwdata = 32'hFFFFFFFF; m_pstrb = 4'hF;
        @(negedge clk);
        m_penable = 1'b1;
        @(negedge clk);
        m_psel = 1'b0; m_penable = 1'b0;
        seen_rdy = 1'b0; seen_pulse = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen_rdy   = seen_rdy | s_ready[1];
            seen_pulse = seen_pulse | s_pulse[1];
        end
        check("abort pready", seen_rdy, 0);
        check("abort wr_pulse", seen_pulse, 0);
        check("abort reg2", s_regout[1][95:64], 0);
        xfer(1, 0, 10'h008, 32'h0, 4'h0, rd, er, lat, pulse, rdy_after);
        check("abort readback", rd, 0);
        check("abort latency", lat, 5);

        // Reset asserted in the 2nd WAIT cycle of a u_c write.
        tgt = 2; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 10'h000; m_pwdata = 32'h12345678; m_pstrb = 4'hF;
        @(negedge clk);
        m_penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid pready", s_ready[2], 0);
        check("rstmid pslverr", s_err[2], 0);
        check("rstmid prdata", s_rdata[2], 0);
        check("rstmid wr_pulse", s_pulse[2], 0);
        check("rstmid reg0", s_regout[2][31:0], 32'hA5A55A5A);
        @(negedge clk);
        m_psel = 1'b0; m_penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_rdy = 1'b0; seen_pulse = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen_rdy   = seen_rdy | s_ready[2];
            seen_pulse = seen_pulse | s_pulse[2];
        end
        check("rstmid no pready", seen_rdy, 0);
        check("rstmid no pulse", seen_pulse, 0);
        check("rstmid reg0 after", s_regout[2][31:0], 32'hA5A55A5A);

        // Reset asserted while u_d is in RESP clears the response at once.
        tgt = 3; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = 10'h000; m_pwdata = 32'h0; m_pstrb = 4'h0;
        @(negedge clk);
        m_penable = 1'b1;
        check("resp pready", s_ready[3], 1);
        check("resp prdata", s_rdata[3], 32'hCAFE0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstresp pready", s_ready[3], 0);
        check("rstresp prdata", s_rdata[3], 0);
        @(negedge clk);
        m_psel = 1'b0; m_penable = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
